// File: rtl/cluster_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cluster_tx_scheduler
// Purpose  : Captures the eight packer clusters of each BX, keeps the valid
//            ones, queues them in a small FIFO and serialises them one per
//            handshake onto a single trigger link. Every word carries the two
//            BX LSBs; clusters lost to a full FIFO are counted.
// Ports    : clock4x         - 160 MHz clock, the only clock
//            global_reset_n  - asynchronous active-low reset
//            cluster_strobe  - first clock4x cycle of a BX, capture point
//            cluster0..7     - {cnt[2:0], adr[10:0]}, cluster0 highest priority
//            tx_ready        - link accepts tx_data this cycle
//            tx_valid        - tx_data holds a cluster
//            tx_data         - {bx_tag[1:0], cnt[2:0], adr[10:0]}
//            fifo_count      - registered FIFO occupancy (0..FIFO_DEPTH)
//            overflow_cnt    - saturating count of clusters dropped on full
// Params   : FIFO_DEPTH (power of 2, 8..16 so the count fits 5 bits)
//            ADR_LIMIT  (cluster valid iff adr < ADR_LIMIT)
// Options  : CLUSTER_SCHED_OVERFLOW_CNT_EN - build the overflow counter;
//            when undefined overflow_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_tx_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADR_LIMIT  = 1536
) (
    input  logic        clock4x,
    input  logic        global_reset_n,
    input  logic        cluster_strobe,
    input  logic [13:0] cluster0,
    input  logic [13:0] cluster1,
    input  logic [13:0] cluster2,
    input  logic [13:0] cluster3,
    input  logic [13:0] cluster4,
    input  logic [13:0] cluster5,
    input  logic [13:0] cluster6,
    input  logic [13:0] cluster7,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic [4:0]  fifo_count,
    output logic [15:0] overflow_cnt
);

    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  C_DEPTH     = 5'(FIFO_DEPTH);
    localparam logic [11:0] C_ADR_LIMIT = 12'(ADR_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
        ST_W2   = 3'd3,
        ST_W3   = 3'd4
    } phase_t;

    // ------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------
    logic [13:0] w_in [8];
    logic [7:0]  w_vmask;
    logic [13:0] r_slot [8];
    logic [7:0]  r_vmask;
    logic [1:0]  r_bx_tag;

    assign w_in[0] = cluster0;
    assign w_in[1] = cluster1;
    assign w_in[2] = cluster2;
    assign w_in[3] = cluster3;
    assign w_in[4] = cluster4;
    assign w_in[5] = cluster5;
    assign w_in[6] = cluster6;
    assign w_in[7] = cluster7;

    always_comb begin
        w_vmask = '0;
        for (int i = 0; i < 8; i++) begin
            w_vmask[i] = ({1'b0, w_in[i][10:0]} < C_ADR_LIMIT);
        end
    end

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= '0;
            end
            r_vmask  <= '0;
            r_bx_tag <= '0;
        end else if (cluster_strobe) begin
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= w_in[i];
            end
            r_vmask  <= w_vmask;
            r_bx_tag <= r_bx_tag + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM: offers one pair of slots per cycle. A new strobe restarts
    // at W0, which silently abandons the pairs not yet offered.
    // ------------------------------------------------------------------
    phase_t     r_state;
    phase_t     w_state_nxt;
    logic       w_offer;
    logic [1:0] w_pair;

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_offer     = 1'b0;
        w_pair      = 2'd0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_W0: begin
                w_offer     = 1'b1;
                w_pair      = 2'd0;
                w_state_nxt = ST_W1;
            end
            ST_W1: begin
                w_offer     = 1'b1;
                w_pair      = 2'd1;
                w_state_nxt = ST_W2;
            end
            ST_W2: begin
                w_offer     = 1'b1;
                w_pair      = 2'd2;
                w_state_nxt = ST_W3;
            end
            ST_W3: begin
                w_offer     = 1'b1;
                w_pair      = 2'd3;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (cluster_strobe) begin
            w_state_nxt = ST_W0;
        end
    end

    // ------------------------------------------------------------------
    // Write arbitration against the registered occupancy. A pop in the
    // same cycle is deliberately not credited, keeping free space off the
    // tx_ready path.
    // ------------------------------------------------------------------
    logic [2:0]  w_idx_lo;
    logic [2:0]  w_idx_hi;
    logic        w_vlo;
    logic        w_vhi;
    logic [15:0] w_word_lo;
    logic [15:0] w_word_hi;
    logic [4:0]  w_free;
    logic        w_wr0;
    logic        w_wr1;
    logic [15:0] w_wr0_data;
    logic [1:0]  w_nwr;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]    r_count;

    assign w_idx_lo  = {w_pair, 1'b0};
    assign w_idx_hi  = {w_pair, 1'b1};
    assign w_vlo     = w_offer & r_vmask[w_idx_lo];
    assign w_vhi     = w_offer & r_vmask[w_idx_hi];
    assign w_word_lo = {r_bx_tag, r_slot[w_idx_lo]};
    assign w_word_hi = {r_bx_tag, r_slot[w_idx_hi]};
    assign w_free    = C_DEPTH - r_count;

    // Port 0 always takes the lowest-numbered surviving slot, so with one
    // free entry the higher slot of a valid pair is the one dropped.
    always_comb begin
        w_wr0      = 1'b0;
        w_wr1      = 1'b0;
        w_wr0_data = w_word_lo;
        if (w_vlo && w_vhi) begin
            w_wr0 = (w_free >= 5'd1);
            w_wr1 = (w_free >= 5'd2);
        end else if (w_vlo) begin
            w_wr0 = (w_free >= 5'd1);
        end else if (w_vhi) begin
            w_wr0      = (w_free >= 5'd1);
            w_wr0_data = w_word_hi;
        end
    end

    assign w_nwr = {1'b0, w_wr0} + {1'b0, w_wr1};

    always_ff @(posedge clock4x) begin
        if (w_wr0) begin
            r_mem[r_wr_ptr] <= w_wr0_data;
        end
        if (w_wr1) begin
            r_mem[r_wr_ptr + PW'(1)] <= w_word_hi;
        end
    end

    // ------------------------------------------------------------------
    // Output register: reloads whenever it is empty or being accepted.
    // ------------------------------------------------------------------
    logic        w_load;
    logic        w_pop;
    logic        r_tx_valid;
    logic [15:0] r_tx_data;

    assign w_load = ~r_tx_valid | tx_ready;
    assign w_pop  = w_load & (r_count != 5'd0);

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_nwr);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + 5'(w_nwr) - 5'(w_pop);
            if (w_load) begin
                r_tx_valid <= w_pop;
                r_tx_data  <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
            end
        end
    end

    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // Overflow counter
    // ------------------------------------------------------------------
`ifdef CLUSTER_SCHED_OVERFLOW_CNT_EN
    logic [1:0]  w_drop;
    logic [16:0] w_ovf_sum;
    logic [15:0] r_ovf;

    // Offered-valid minus written is exactly the number rejected for space.
    assign w_drop    = ({1'b0, w_vlo} + {1'b0, w_vhi}) - w_nwr;
    assign w_ovf_sum = {1'b0, r_ovf} + 17'(w_drop);

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_ovf <= '0;
        end else if (w_drop != 2'd0) begin
            r_ovf <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
        end
    end

    assign overflow_cnt = r_ovf;
`else
    assign overflow_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cluster_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cluster_tx_scheduler
// Purpose  : Directed self-checking bench for cluster_tx_scheduler.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_tx_scheduler;

`ifdef CLUSTER_SCHED_OVERFLOW_CNT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    localparam logic [13:0] NONE = {3'd0, 11'h7FF};

    logic        clock4x = 1'b0;
    logic        global_reset_n;
    logic        cluster_strobe;
    logic        tx_ready;
    logic [13:0] cl [8];
    logic        tx_valid;
    logic [15:0] tx_data;
    logic [4:0]  fifo_count;
    logic [15:0] overflow_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] got [$];
    logic [15:0] exp_q [$];
    logic [15:0] primer;

    always #5 clock4x = ~clock4x;

    cluster_tx_scheduler dut (
        .clock4x        (clock4x),
        .global_reset_n (global_reset_n),
        .cluster_strobe (cluster_strobe),
        .cluster0       (cl[0]),
        .cluster1       (cl[1]),
        .cluster2       (cl[2]),
        .cluster3       (cl[3]),
        .cluster4       (cl[4]),
        .cluster5       (cl[5]),
        .cluster6       (cl[6]),
        .cluster7       (cl[7]),
        .tx_ready       (tx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .fifo_count     (fifo_count),
        .overflow_cnt   (overflow_cnt)
    );

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] mk_word(input logic [1:0] tag,
                                            input logic [2:0] cnt,
                                            input logic [10:0] adr);
        return {tag, cnt, adr};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock4x);
    endtask

    task automatic strobe();
        cluster_strobe = 1'b1;
        tick(1);
        cluster_strobe = 1'b0;
    endtask

    task automatic apply_reset();
        global_reset_n = 1'b0;
        tick(2);
        global_reset_n = 1'b1;
        tick(1);
    endtask

    task automatic set_none();
        for (int i = 0; i < 8; i++) cl[i] = NONE;
    endtask

    // Gathers up to n accepted words within a cycle budget. With toggle set,
    // tx_ready alternates and held data is checked across every stall.
    task automatic collect(input int n, input int budget, input bit toggle);
        logic [15:0] held = 16'h0;
        bit          stalled = 1'b0;
        got.delete();
        for (int c = 0; c < budget && got.size() < n; c++) begin
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (stalled) check_value("hold_stable", tx_data, held);
            stalled = 1'b0;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
            end else if (tx_valid) begin
                stalled = 1'b1;
                held    = tx_data;
            end
            tick(1);
        end
        check_value("word_count", got.size(), n);
    endtask

    task automatic compare_words(input string tag);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check_value(tag, got[i], exp_q[i]);
        end
    endtask

    initial begin
        global_reset_n = 1'b0;
        cluster_strobe = 1'b0;
        tx_ready       = 1'b0;
        set_none();

        // ---- 1: reset state ----
        tick(2);
        check_value("rst_valid", tx_valid, 0);
        check_value("rst_data", tx_data, 0);
        check_value("rst_count", fifo_count, 0);
        check_value("rst_ovf", overflow_cnt, 0);
        global_reset_n = 1'b1;
        tick(1);
        check_value("post_rst_valid", tx_valid, 0);

        // ---- 2: single cluster latency ----
        tx_ready = 1'b1;
        cl[0] = {3'd2, 11'd5};
        strobe();
        check_value("lat_t1_valid", tx_valid, 0);
        tick(1);
        check_value("lat_t2_valid", tx_valid, 0);
        check_value("lat_t2_count", fifo_count, 1);
        tick(1);
        check_value("lat_t3_valid", tx_valid, 1);
        check_value("lat_t3_data", tx_data, 16'h5005);
        check_value("lat_t3_count", fifo_count, 0);
        tick(1);
        check_value("lat_t4_valid", tx_valid, 0);
        check_value("lat_t4_data", tx_data, 0);

        // ---- 3: all eight valid, first BX after reset tagged 1 ----
        apply_reset();
        tx_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            cl[i] = {3'(i), 11'(i)};
            exp_q.push_back(mk_word(2'd1, 3'(i), 11'(i)));
        end
        strobe();
        collect(8, 40, 1'b0);
        compare_words("all8_word");
        tick(3);
        check_value("all8_no_extra", tx_valid, 0);
        check_value("all8_count", fifo_count, 0);
        check_value("all8_ovf", overflow_cnt, 0);

        // ---- 5: tx_ready toggling, address-limit boundaries, tag 2 ----
        exp_q.delete();
        for (int i = 0; i < 8; i++) cl[i] = {3'(7 - i), 11'(100 + i)};
        cl[3] = {3'd4, 11'd1536};
        cl[5] = {3'd2, 11'd1535};
        cl[6] = {3'd1, 11'h7FE};
        for (int i = 0; i < 8; i++) begin
            if (i != 3 && i != 6) exp_q.push_back(mk_word(2'd2, cl[i][13:11], cl[i][10:0]));
        end
        tx_ready = 1'b0;
        strobe();
        collect(6, 60, 1'b1);
        compare_words("toggle_word");
        tx_ready = 1'b1;
        tick(3);
        check_value("toggle_no_extra", tx_valid, 0);
        check_value("toggle_count", fifo_count, 0);

        // ---- 4: overflow with link stalled ----
        // The output register absorbs one word even while stalled, so a
        // primer cluster fills it first and the FIFO alone sees the 3 BXs.
        apply_reset();
        tx_ready = 1'b0;
        set_none();
        cl[0]  = {3'd1, 11'd9};
        primer = mk_word(2'd1, 3'd1, 11'd9);
        strobe();
        tick(5);
        check_value("primer_valid", tx_valid, 1);
        check_value("primer_data", tx_data, primer);
        check_value("primer_count", fifo_count, 0);
        exp_q.delete();
        exp_q.push_back(primer);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                cl[i] = {3'(i), 11'(64 * (b + 1) + i)};
                if (b < 2) exp_q.push_back(mk_word(2'(b + 2), 3'(i), 11'(64 * (b + 1) + i)));
            end
            strobe();
            tick(3);
        end
        tick(3);
        check_value("ovf_count", fifo_count, 16);
        check_value("ovf_cnt", overflow_cnt, OVF_ON ? 8 : 0);
        check_value("ovf_stall_data", tx_data, primer);
        collect(17, 80, 1'b0);
        compare_words("ovf_word");
        tick(2);
        check_value("ovf_drained", fifo_count, 0);
        check_value("ovf_cnt_kept", overflow_cnt, OVF_ON ? 8 : 0);
        check_value("ovf_no_extra", tx_valid, 0);

        // ---- 6a: strobes 2 cycles apart, first BX truncated to slots 0-3 ----
        apply_reset();
        tx_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) cl[i] = {3'(i), 11'(32 + i)};
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_word(2'd1, 3'(i), 11'(32 + i)));
        strobe();
        tick(1);
        for (int i = 0; i < 8; i++) begin
            cl[i] = {3'(7 - i), 11'(64 + i)};
            exp_q.push_back(mk_word(2'd2, 3'(7 - i), 11'(64 + i)));
        end
        strobe();
        collect(12, 60, 1'b0);
        compare_words("close_word");
        tick(3);
        check_value("close_no_extra", tx_valid, 0);
        check_value("close_ovf", overflow_cnt, 0);

        // ---- 6b: async reset in the middle of W1 ----
        tx_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) cl[i] = {3'(i), 11'(32 + i)};
        strobe();
        tick(1);
        for (int i = 0; i < 8; i++) cl[i] = {3'(i), 11'(64 + i)};
        strobe();
        check_value("mid_count_w0", fifo_count, 3);
        check_value("mid_data_w0", tx_data, mk_word(2'd1, 3'd0, 11'd32));
        tick(1);
        check_value("mid_count_w1", fifo_count, 5);
        #2;
        global_reset_n = 1'b0;
        #1;
        check_value("async_count", fifo_count, 0);
        check_value("async_valid", tx_valid, 0);
        check_value("async_data", tx_data, 0);
        tick(1);
        global_reset_n = 1'b1;
        tick(3);
        check_value("after_async_count", fifo_count, 0);
        check_value("after_async_ovf", overflow_cnt, 0);
        check_value("after_async_valid", tx_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
